// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate operand sequencer: mode encodings,
// key count and a counter-width helper that keeps 1-cycle parameters legal.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_HOLD   = 2'b10
  } mode_e;

  localparam int unsigned NUM_KEYS = 2;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One board button: 2-flop synchronizer, stability counter, debounced
// level (1 = pressed) and a single-cycle press pulse on the 0->1 edge.
module key_debounce
  import gate_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_out;
  logic [CW-1:0] count;
  logic          differ;

  // Raw key is active-low; compare its pressed sense with the held level.
  assign differ = (~sync_out) != level;

  // Two-stage synchronizer for the asynchronous button input.
  // NOTE: synchronizer flops reset to 1 so a held reset looks like a released key.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      sync_out  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two stages a true shift register.
      sync_meta <= key_raw;
      sync_out  <= sync_meta;
    end
  end

  // Count consecutive disagreeing cycles; flip the level once the run is long enough.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (!differ) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        count <= '0;
        level <= ~level;
        press <= ~level;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_sequencer.sv
// Drives operands a/b of a gate datapath either straight from two debounced
// buttons (MANUAL), from a timed 2-bit step counter (AUTO), or from that
// counter frozen and single-stepped by hand (HOLD). Both buttons together
// toggle between MANUAL and the automatic modes.
module gate_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STEP_CYCLES     = 25000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] key,
  output logic       a,
  output logic       b,
  output logic [1:0] mode,
  output logic       step_strobe
);

  localparam int unsigned   TW         = cnt_width(STEP_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] press_eff;
  logic                both_q;
  logic                chord;

  mode_e               state;
  mode_e               state_next;
  logic [1:0]          step;
  logic [1:0]          step_next;
  logic [TW-1:0]       timer;
  logic [TW-1:0]       timer_next;
  logic                strobe_next;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock  (clock),
      .reset_n(reset_n),
      .key_raw(key[i]),
      .level  (level[i]),
      .press  (press[i])
    );
  end

  // A chord is the first cycle with both levels high; it swallows any
  // single press pulse that arrives together with it.
  assign chord     = (&level) & ~both_q;
  assign press_eff = chord ? '0 : press;

  // State register plus step, dwell timer and strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= MODE_MANUAL;
      step        <= 2'b00;
      timer       <= '0;
      step_strobe <= 1'b0;
      both_q      <= 1'b0;
    end else begin
      state       <= state_next;
      step        <= step_next;
      timer       <= timer_next;
      step_strobe <= strobe_next;
      both_q      <= &level;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_next  = state;
    step_next   = step;
    timer_next  = timer;
    strobe_next = 1'b0;
    case (state)
      MODE_MANUAL: begin
        if (chord) begin
          state_next = MODE_AUTO;
          step_next  = 2'b00;
          timer_next = '0;
        end
      end
      MODE_AUTO: begin
        if (chord) begin
          state_next = MODE_MANUAL;
          step_next  = 2'b00;
          timer_next = '0;
        end else begin
          if (timer == TIMER_LAST) begin
            timer_next  = '0;
            step_next   = step + 2'd1;
            strobe_next = 1'b1;
          end else if (!press_eff[0]) begin
            timer_next = timer + 1'b1;
          end
          // Entering HOLD freezes the timer where it stands.
          if (press_eff[0]) begin
            state_next = MODE_HOLD;
          end
        end
      end
      MODE_HOLD: begin
        if (chord) begin
          state_next = MODE_MANUAL;
          step_next  = 2'b00;
          timer_next = '0;
        end else if (press_eff[0]) begin
          state_next = MODE_AUTO;
          timer_next = '0;
        end else if (press_eff[1]) begin
          step_next   = step + 2'd1;
          strobe_next = 1'b1;
        end
      end
      default: begin
        state_next = MODE_MANUAL;
        step_next  = 2'b00;
        timer_next = '0;
      end
    endcase
  end

  // Output selection from registered state only.
  always_comb begin
    mode = state;
    if (state == MODE_MANUAL) begin
      a = level[0];
      b = level[1];
    end else begin
      a = step[0];
      b = step[1];
    end
  end

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer with DEBOUNCE_CYCLES = 4, STEP_CYCLES = 8.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// before new inputs are applied. A key level change seen at the pins shows up
// on the debounced level 6 rising edges later (2 sync + 4 stable cycles), and
// a resulting mode/step change one edge after that.
module tb_gate_sequencer;

  logic       clock;
  logic       reset_n;
  logic [1:0] key;
  logic       a;
  logic       b;
  logic [1:0] mode;
  logic       step_strobe;

  int n_asserts = 0;
  int n_fail    = 0;
  int strobes   = 0;

  gate_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES    (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .key        (key),
    .a          (a),
    .b          (b),
    .mode       (mode),
    .step_strobe(step_strobe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [1:0] m, input logic [1:0] ba, input logic s);
    logic [4:0] obs;
    logic [4:0] req;
    obs = {mode, b, a, step_strobe};
    req = {m, ba, s};
    n_asserts++;
    assert (obs === req)
    else begin
      n_fail++;
      $error("FAIL %s: observed mode=%b ba=%b%b strobe=%b, expected mode=%b ba=%b strobe=%b",
             tag, mode, b, a, step_strobe, m, ba, s);
    end
  endtask

  initial begin
    logic [1:0] exp_step;
    logic       exp_s;

    // Reset held with both keys pressed: outputs stay at reset values.
    reset_n = 1'b0;
    key     = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("reset_hold", 2'b00, 2'b00, 1'b0);
    end
    key = 2'b11;
    tick(1);
    reset_n = 1'b1;
    tick(8);
    check("idle_after_reset", 2'b00, 2'b00, 1'b0);

    // Bounce: key[0] low 3 cycles, high 1, then low held.
    key = 2'b10;
    tick(3);
    check("bounce_early", 2'b00, 2'b00, 1'b0);
    key = 2'b11;
    tick(1);
    key = 2'b10;
    tick(5);
    check("bounce_before_rise", 2'b00, 2'b00, 1'b0);
    tick(1);
    check("bounce_rise", 2'b00, 2'b01, 1'b0);
    tick(3);
    check("bounce_level_held", 2'b00, 2'b01, 1'b0);

    // Release key[0]: level falls after the same debounce delay.
    key = 2'b11;
    tick(5);
    check("release_before_fall", 2'b00, 2'b01, 1'b0);
    tick(1);
    check("release_fall", 2'b00, 2'b00, 1'b0);

    // Chord in MANUAL enters AUTO one cycle after both levels rise.
    key = 2'b00;
    tick(6);
    check("chord_levels", 2'b00, 2'b11, 1'b0);
    tick(1);
    check("enter_auto", 2'b01, 2'b00, 1'b0);
    key = 2'b11;
    // AUTO wrap: step advances every 8 cycles, 00,01,10,11,00.
    for (int k = 8; k <= 39; k++) begin
      tick(1);
      exp_step = 2'((k - 7) / 8);
      exp_s    = ((k - 7) % 8) == 0;
      check("auto_wrap", 2'b01, exp_step, exp_s);
      strobes += int'(step_strobe);
    end
    n_asserts++;
    assert (strobes === 4)
    else begin
      n_fail++;
      $error("FAIL auto_strobe_count: observed %0d, expected 4", strobes);
    end

    // HOLD entry at step 01 with the timer mid-count.
    tick(8);
    check("auto_step01", 2'b01, 2'b01, 1'b1);
    key = 2'b10;
    tick(6);
    check("auto_before_hold", 2'b01, 2'b01, 1'b0);
    tick(1);
    check("enter_hold", 2'b10, 2'b01, 1'b0);
    key = 2'b11;
    tick(12);
    check("hold_frozen", 2'b10, 2'b01, 1'b0);

    // Two key[1] presses single-step to 11.
    key = 2'b01;
    tick(6);
    check("hold_step1_wait", 2'b10, 2'b01, 1'b0);
    tick(1);
    check("hold_step1", 2'b10, 2'b10, 1'b1);
    key = 2'b11;
    tick(1);
    check("hold_step1_strobe_end", 2'b10, 2'b10, 1'b0);
    tick(6);
    key = 2'b01;
    tick(7);
    check("hold_step2", 2'b10, 2'b11, 1'b1);
    key = 2'b11;
    tick(1);
    check("hold_step2_strobe_end", 2'b10, 2'b11, 1'b0);

    // key[0] in HOLD returns to AUTO with step kept, timer cleared;
    // then a key[0] press lands exactly on a terminal count.
    tick(6);
    key = 2'b10;
    tick(7);
    check("resume_auto", 2'b01, 2'b11, 1'b0);
    key = 2'b11;
    tick(8);
    check("resume_wrap", 2'b01, 2'b00, 1'b1);
    tick(1);
    check("resume_after_wrap", 2'b01, 2'b00, 1'b0);
    key = 2'b10;
    tick(6);
    check("coincide_before", 2'b01, 2'b00, 1'b0);
    tick(1);
    check("coincide", 2'b10, 2'b01, 1'b1);
    tick(1);
    check("coincide_after", 2'b10, 2'b01, 1'b0);
    key = 2'b11;

    // Chord in HOLD returns to MANUAL; outputs then follow the keys.
    tick(6);
    key = 2'b00;
    tick(6);
    check("hold_before_chord", 2'b10, 2'b01, 1'b0);
    tick(1);
    check("chord_exit", 2'b00, 2'b11, 1'b0);
    key = 2'b10;
    tick(6);
    check("manual_follow", 2'b00, 2'b01, 1'b0);
    key = 2'b11;

    // Re-enter AUTO, advance a step, then reset mid-run.
    tick(6);
    key = 2'b00;
    tick(7);
    check("reenter_auto", 2'b01, 2'b00, 1'b0);
    key = 2'b11;
    tick(8);
    check("reenter_step", 2'b01, 2'b01, 1'b1);
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async", 2'b00, 2'b00, 1'b0);
    tick(2);
    check("reset_held_mid", 2'b00, 2'b00, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("after_reset_idle", 2'b00, 2'b00, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter STEP_CYCLES, default 25000000, meaning AUTO-mode dwell per operand combination (0.5 s at 50 MHz).
REQ-003 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key  input  2  raw board buttons, active-low, asynchronous to clock.
REQ-006 SHALL have port a  output  1  gate operand A for the gate datapath.
REQ-007 SHALL have port b  output  1  gate operand B for the gate datapath.
REQ-008 SHALL have port mode  output  2  current state: 00 MANUAL, 01 AUTO, 10 HOLD.
REQ-009 SHALL have port step_strobe  output  1  one-cycle pulse whenever the operand step advances.

Function
REQ-010 SHALL pass each key bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep, per key, a debounced level (1 = pressed); it flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the count.
REQ-012 SHALL generate, per key, a one-cycle press pulse in the cycle the debounced level goes 0->1; releases generate no pulse.
REQ-013 SHALL generate a chord event in the cycle both debounced levels are 1 and were not both 1 the previous cycle.
REQ-014 SHALL give a chord event priority over any coincident single press pulse; those press pulses are discarded.
REQ-015 SHALL, in MANUAL, drive a = debounced key[0] level and b = debounced key[1] level.
REQ-016 SHALL, in AUTO and HOLD, drive {b,a} = 2-bit step register.
REQ-017 SHALL, on chord in MANUAL, enter AUTO with step = 00 and dwell timer = 0.
REQ-018 SHALL, in AUTO, count the timer 0..STEP_CYCLES-1; at terminal count clear it, advance step 00->01->10->11->00 (wrap) and pulse step_strobe.
REQ-019 SHALL, on key[0] press in AUTO, enter HOLD, freezing step and timer.
REQ-020 SHALL, when the terminal count and a key[0] press coincide in AUTO, both advance step (with strobe) and enter HOLD.
REQ-021 SHALL, on key[1] press in HOLD, advance step by one with wrap and pulse step_strobe; key[1] press in AUTO is ignored.
REQ-022 SHALL, on key[0] press in HOLD, return to AUTO with timer cleared and step unchanged.
REQ-023 SHALL, on chord in AUTO or HOLD, return to MANUAL; step and timer are cleared.
REQ-024 SHALL derive all outputs from registered state only; no combinational path from key to outputs.

Reset
REQ-025 SHALL, while reset_n = 0, force mode = MANUAL, step = 00, timer = 0, debounce counters = 0, debounced levels = 0, synchronizer flops = 1 (released), a = 0, b = 0, step_strobe = 0.
REQ-026 SHALL, on reset assertion mid-operation (any state, any count), discard all pending work; no strobe is emitted on release.

Structure
REQ-027 SHALL take the mode encodings (MANUAL, AUTO, HOLD) from shared package gate_seq_pkg; the state register uses them directly.
REQ-028 SHALL instantiate sub-module key_debounce once per key (synchronizer, counter, level, press pulse), parameterised by DEBOUNCE_CYCLES.
REQ-029 SHALL size counters as $clog2 of their parameters; DEBOUNCE_CYCLES and STEP_CYCLES of 1 shall be legal.

Verification (DEBOUNCE_CYCLES = 4, STEP_CYCLES = 8)
REQ-030 SHALL cover a reset check: reset_n low with key = 2'b00 -> mode = 00, a = b = 0, step_strobe = 0 throughout.
REQ-031 SHALL cover a bounce check: key[0] low 3 cycles, high 1, then low held -> a rises only after 4 consecutive low synchronized cycles; exactly one press pulse.
REQ-032 SHALL cover AUTO wrap: a chord in MANUAL -> mode = 01, {b,a} steps 00,01,10,11,00 every 8 cycles, 4 strobes.
REQ-033 SHALL cover HOLD single-step: key[0] press in AUTO at step 01 -> mode = 10, frozen; two key[1] presses -> {b,a} = 11, two strobes.
REQ-034 SHALL cover the coincidence case: a key[0] press landing on a terminal count -> step advances once, strobe once, mode = 10.
REQ-035 SHALL cover chord exit and mid-run reset: a chord in HOLD -> mode = 00, {b,a} follows keys; reset asserted mid-AUTO -> all outputs reset values immediately.
